// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: bus stage behind the 65CE02 core. Captures the core's
// look-ahead bus outputs and steers each access either to on-chip fast memory
// (1-cycle synchronous read) or to a slow external region reached over a
// level req/ack handshake with minimum wait states and a timeout.
module cpu_mem_bridge #(
    parameter logic [15:0] SLOW_BASE   = 16'hD000,
    parameter logic [15:0] SLOW_MASK   = 16'hF000,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address_next,
    input  logic        cpu_write_next,
    input  logic [7:0]  cpu_data_o_next,
    output logic        cpu_ready,
    output logic [7:0]  cpu_data_i,
    output logic [15:0] fm_addr,
    output logic        fm_we,
    output logic [7:0]  fm_wdata,
    input  logic [7:0]  fm_rdata,
    output logic        sb_req,
    output logic        sb_we,
    output logic [15:0] sb_addr,
    output logic [7:0]  sb_wdata,
    input  logic [7:0]  sb_rdata,
    input  logic        sb_ack,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WCNT_INIT = 4'(WAIT_STATES);
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic [3:0]  wcnt;
    logic [3:0]  wcnt_next;
    logic [7:0]  tcnt;
    logic [7:0]  tcnt_next;
    logic        ack_clear;
    logic        ack_clear_next;
    logic [7:0]  rd_latch;
    logic [7:0]  rd_latch_next;
    logic        txn_slow;
    logic        txn_slow_next;
    logic        sb_req_next;
    logic        sb_we_next;
    logic [15:0] sb_addr_next;
    logic [7:0]  sb_wdata_next;
    logic        bus_timeout_next;

    logic        next_slow;
    logic        ack_accept;
    logic        timeout_hit;

    // Address decode of the look-ahead address: does the coming cycle target the slow region?
    always_comb begin
        next_slow = ((cpu_address_next & SLOW_MASK) == SLOW_BASE);
    end

    // Core-facing outputs and fast-memory port; ready depends on registered state only.
    always_comb begin
        cpu_ready  = (state != S_WAIT);
        cpu_data_i = ((state == S_DONE) && txn_slow) ? rd_latch : fm_rdata;
        fm_addr    = cpu_address_next;
        fm_wdata   = cpu_data_o_next;
        fm_we      = cpu_write_next & cpu_ready & ~next_slow;
    end

    // Next-state and next-register logic for the capture / wait / done sequence.
    always_comb begin
        state_next       = state;
        wcnt_next        = wcnt;
        tcnt_next        = tcnt;
        ack_clear_next   = ack_clear;
        rd_latch_next    = rd_latch;
        txn_slow_next    = txn_slow;
        sb_req_next      = sb_req;
        sb_we_next       = sb_we;
        sb_addr_next     = sb_addr;
        sb_wdata_next    = sb_wdata;
        bus_timeout_next = 1'b0;
        ack_accept       = 1'b0;
        timeout_hit      = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                txn_slow_next = next_slow;
                if (next_slow) begin
                    state_next     = S_WAIT;
                    sb_req_next    = 1'b1;
                    sb_we_next     = cpu_write_next;
                    sb_addr_next   = cpu_address_next;
                    sb_wdata_next  = cpu_data_o_next;
                    wcnt_next      = WCNT_INIT;
                    tcnt_next      = 8'd0;
                    ack_clear_next = ~sb_ack;
                end else begin
                    state_next = S_IDLE;
                end
            end

            S_WAIT: begin
                ack_accept  = sb_ack & ack_clear & (wcnt == 4'd0);
                timeout_hit = (tcnt == TCNT_LAST);
                if (ack_accept) begin
                    rd_latch_next = sb_rdata;
                    sb_req_next   = 1'b0;
                    state_next    = S_DONE;
                end else if (timeout_hit) begin
                    rd_latch_next    = 8'hFF;
                    sb_req_next      = 1'b0;
                    state_next       = S_DONE;
                    bus_timeout_next = 1'b1;
                end else begin
                    tcnt_next = tcnt + 8'd1;
                    if (!ack_clear && sb_ack) begin
                        wcnt_next = (wcnt > 4'd1) ? (wcnt - 4'd1) : 4'd1;
                    end else begin
                        wcnt_next = (wcnt != 4'd0) ? (wcnt - 4'd1) : 4'd0;
                    end
                    if (!sb_ack) begin
                        ack_clear_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any outstanding slow transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake, counter and data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt        <= 4'd0;
            tcnt        <= 8'd0;
            ack_clear   <= 1'b0;
            rd_latch    <= 8'd0;
            txn_slow    <= 1'b0;
            sb_req      <= 1'b0;
            sb_we       <= 1'b0;
            sb_addr     <= 16'd0;
            sb_wdata    <= 8'd0;
            bus_timeout <= 1'b0;
        end else begin
            wcnt        <= wcnt_next;
            tcnt        <= tcnt_next;
            ack_clear   <= ack_clear_next;
            rd_latch    <= rd_latch_next;
            txn_slow    <= txn_slow_next;
            sb_req      <= sb_req_next;
            sb_we       <= sb_we_next;
            sb_addr     <= sb_addr_next;
            sb_wdata    <= sb_wdata_next;
            bus_timeout <= bus_timeout_next;
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: directed scenarios followed by randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_cpu_mem_bridge;

    localparam int WS = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_address_next;
    logic        cpu_write_next;
    logic [7:0]  cpu_data_o_next;
    logic        cpu_ready;
    logic [7:0]  cpu_data_i;
    logic [15:0] fm_addr;
    logic        fm_we;
    logic [7:0]  fm_wdata;
    logic [7:0]  fm_rdata;
    logic        sb_req;
    logic        sb_we;
    logic [15:0] sb_addr;
    logic [7:0]  sb_wdata;
    logic [7:0]  sb_rdata;
    logic        sb_ack;
    logic        bus_timeout;

    cpu_mem_bridge #(
        .SLOW_BASE  (16'hD000),
        .SLOW_MASK  (16'hF000),
        .WAIT_STATES(WS),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_address_next(cpu_address_next),
        .cpu_write_next  (cpu_write_next),
        .cpu_data_o_next (cpu_data_o_next),
        .cpu_ready       (cpu_ready),
        .cpu_data_i      (cpu_data_i),
        .fm_addr         (fm_addr),
        .fm_we           (fm_we),
        .fm_wdata        (fm_wdata),
        .fm_rdata        (fm_rdata),
        .sb_req          (sb_req),
        .sb_we           (sb_we),
        .sb_addr         (sb_addr),
        .sb_wdata        (sb_wdata),
        .sb_rdata        (sb_rdata),
        .sb_ack          (sb_ack),
        .bus_timeout     (bus_timeout)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Fast memory with one-cycle synchronous read.
    logic [7:0] fastMem [0:65535];
    always @(posedge clk) begin
        if (fm_we) fastMem[fm_addr] <= fm_wdata;
        fm_rdata <= fastMem[fm_addr];
    end

    int total = 0;
    int bad = 0;

    // Reference model state, expressed as "transaction in flight" facts.
    logic [7:0]  refMem [logic [15:0]];
    bit          mBusy;
    int          mAge;
    bit          mLowSeen;
    bit          mDone;
    bit          mTimeout;
    logic [7:0]  mLatch;
    bit          mReq;
    bit          mSbWe;
    logic [15:0] mSbAddr;
    logic [7:0]  mSbWdata;
    bit          mFastRead;
    logic [7:0]  mFastData;

    // Slave behaviour knobs and bookkeeping.
    int slvDelay;
    bit slvNoAck;
    int slvLinger;
    bit randomAck;
    int lingerLeft;
    bit gap;
    int reqAge;
    bit prevReq;

    function automatic bit isSlow(input logic [15:0] a);
        return (a >= 16'hD000) && (a <= 16'hDFFF);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        mBusy = 0; mAge = 0; mLowSeen = 0; mDone = 0; mTimeout = 0; mLatch = 8'h00;
        mReq = 0; mSbWe = 0; mSbAddr = 16'h0000; mSbWdata = 8'h00;
        mFastRead = 0; mFastData = 8'h00;
        lingerLeft = 0; gap = 0; reqAge = 0; prevReq = 0;
    endtask

    // Slave response for the coming cycle, driven from the expected request level.
    task automatic driveSlave();
        if (prevReq && !mReq) begin
            lingerLeft = slvLinger;
            gap = (slvLinger > 0);
        end
        prevReq = mReq;
        sb_rdata = 8'($urandom);
        if (randomAck) begin
            sb_ack = 1'($urandom_range(0, 1));
        end else if (lingerLeft > 0) begin
            lingerLeft--;
            reqAge = 0;
        end else if (gap) begin
            sb_ack = 1'b0;
            gap = 0;
            reqAge = 0;
        end else if (mReq && !slvNoAck) begin
            reqAge++;
            sb_ack = (reqAge > slvDelay);
        end else begin
            sb_ack = 1'b0;
            if (!mReq) reqAge = 0;
        end
    endtask

    // Reference behaviour at a clock edge, using the values present at that edge.
    task automatic modelEdge();
        if (!mBusy) begin
            mDone = 0; mTimeout = 0; mFastRead = 0;
            if (isSlow(cpu_address_next)) begin
                mBusy = 1; mAge = 0; mLowSeen = !sb_ack; mReq = 1;
                mSbWe = cpu_write_next; mSbAddr = cpu_address_next; mSbWdata = cpu_data_o_next;
            end else if (cpu_write_next) begin
                refMem[cpu_address_next] = cpu_data_o_next;
            end else if (refMem.exists(cpu_address_next)) begin
                mFastRead = 1;
                mFastData = refMem[cpu_address_next];
            end
        end else begin
            mAge++;
            if (sb_ack && mLowSeen && mAge >= WS + 1) begin
                mBusy = 0; mReq = 0; mDone = 1; mLatch = sb_rdata;
            end else if (mAge == TO) begin
                mBusy = 0; mReq = 0; mDone = 1; mLatch = 8'hFF; mTimeout = 1;
            end else if (!sb_ack) begin
                mLowSeen = 1;
            end
        end
    endtask

    // One core cycle: present inputs at the falling edge, check after the rising edge.
    task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] data);
        cpu_address_next = addr;
        cpu_write_next = we;
        cpu_data_o_next = data;
        driveSlave();
        #1;
        checkOutput("fm_we", 32'(fm_we), 32'(we && !mBusy && !isSlow(addr)));
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("cpu_ready", 32'(cpu_ready), 32'(!mBusy));
        checkOutput("sb_req", 32'(sb_req), 32'(mReq));
        checkOutput("bus_timeout", 32'(bus_timeout), 32'(mTimeout));
        if (mReq) begin
            checkOutput("sb_we", 32'(sb_we), 32'(mSbWe));
            checkOutput("sb_addr", 32'(sb_addr), 32'(mSbAddr));
            checkOutput("sb_wdata", 32'(sb_wdata), 32'(mSbWdata));
        end
        if (mDone) checkOutput("done_data", 32'(cpu_data_i), 32'(mLatch));
        else if (mFastRead) checkOutput("fast_data", 32'(cpu_data_i), 32'(mFastData));
        @(negedge clk);
    endtask

    // One transaction plus idle cycles until the core is released; checks stall length.
    task automatic runTxn(input logic [15:0] addr, input logic we, input logic [7:0] data,
                          input int expLow, input string tag);
        int lowCount;
        lowCount = 0;
        applyStimulus(addr, we, data);
        while (cpu_ready === 1'b0 && lowCount < 300) begin
            lowCount++;
            applyStimulus(16'h0010, 1'b0, 8'h00);
        end
        checkOutput({tag, "_stall"}, 32'(lowCount), 32'(expLow));
    endtask

    initial begin
        logic [15:0] edgeAddr [4];
        logic [15:0] addr;
        edgeAddr[0] = 16'hCFFF; edgeAddr[1] = 16'hD000;
        edgeAddr[2] = 16'hDFFF; edgeAddr[3] = 16'hE000;

        reset = 1'b1;
        cpu_address_next = 16'h0010; cpu_write_next = 1'b0; cpu_data_o_next = 8'h00;
        sb_ack = 1'b0; sb_rdata = 8'h00;
        slvDelay = 0; slvNoAck = 0; slvLinger = 0; randomAck = 0;
        resetModel();
        #1 reset = 1'b0;
        #11;
        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(cpu_ready), 32'd1);
        checkOutput("rst_req", 32'(sb_req), 32'd0);
        checkOutput("rst_we", 32'(sb_we), 32'd0);
        checkOutput("rst_addr", 32'(sb_addr), 32'd0);
        checkOutput("rst_wdata", 32'(sb_wdata), 32'd0);
        checkOutput("rst_timeout", 32'(bus_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] fast write then read 0x0200");
        runTxn(16'h0200, 1'b1, 8'h5A, 0, "fast_wr");
        runTxn(16'h0200, 1'b0, 8'h00, 0, "fast_rd");
        checkOutput("fast_rd_5a", 32'(cpu_data_i), 32'h5A);

        $display("[TB] slow read 0xD012, ack held from request");
        slvDelay = 0;
        runTxn(16'hD012, 1'b0, 8'h00, 3, "slow_rd");

        $display("[TB] slow write 0xD7FF, ack at 5th request cycle");
        slvDelay = 4;
        runTxn(16'hD7FF, 1'b1, 8'h99, 5, "slow_wr");

        $display("[TB] no ack, timeout");
        slvNoAck = 1;
        runTxn(16'hD400, 1'b0, 8'h00, TO, "timeout");
        checkOutput("timeout_pulse", 32'(bus_timeout), 32'd1);
        checkOutput("timeout_data", 32'(cpu_data_i), 32'hFF);
        applyStimulus(16'h0010, 1'b0, 8'h00);
        slvNoAck = 0;

        $display("[TB] ack on the timeout cycle");
        slvDelay = TO - 1;
        runTxn(16'hD401, 1'b0, 8'h00, TO, "ack_at_to");
        checkOutput("ack_at_to_pulse", 32'(bus_timeout), 32'd0);

        $display("[TB] back-to-back slow with lingering ack");
        slvDelay = 0; slvLinger = 2;
        runTxn(16'hD100, 1'b0, 8'h00, 3, "b2b_a");
        runTxn(16'hD101, 1'b0, 8'h00, 3, "b2b_b");
        slvLinger = 4;
        runTxn(16'hD102, 1'b1, 8'h3C, 5, "b2b_c");
        slvLinger = 0;
        repeat (6) applyStimulus(16'h0010, 1'b0, 8'h00);

        $display("[TB] reset during wait");
        slvNoAck = 1;
        applyStimulus(16'hD020, 1'b0, 8'h00);
        applyStimulus(16'h0010, 1'b0, 8'h00);
        applyStimulus(16'h0010, 1'b0, 8'h00);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_req", 32'(sb_req), 32'd0);
        checkOutput("midrst_ready", 32'(cpu_ready), 32'd1);
        checkOutput("midrst_timeout", 32'(bus_timeout), 32'd0);
        resetModel();
        sb_ack = 1'b0;
        slvNoAck = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        runTxn(16'h0300, 1'b1, 8'hA7, 0, "post_rst_wr");
        runTxn(16'h0300, 1'b0, 8'h00, 0, "post_rst_rd");
        checkOutput("post_rst_data", 32'(cpu_data_i), 32'hA7);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            if (i == 1000) randomAck = 1;
            if (!mBusy && lingerLeft == 0 && !gap) begin
                slvDelay = $urandom_range(0, 9);
                slvNoAck = ($urandom_range(0, 7) == 0);
                slvLinger = $urandom_range(0, 3);
            end
            case ($urandom_range(0, 5))
                0, 1: addr = 16'h0100 | 16'($urandom_range(0, 15));
                2:    addr = 16'hD000 | 16'($urandom_range(0, 15));
                3:    addr = edgeAddr[$urandom_range(0, 3)];
                4:    addr = 16'($urandom);
                default: addr = 16'hD800 | 16'($urandom_range(0, 255));
            endcase
            applyStimulus(addr, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        randomAck = 0; lingerLeft = 0; gap = 0; reqAge = 0;
        slvNoAck = 0; slvDelay = 1;
        repeat (20) applyStimulus(16'h0010, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Bus stage directly downstream of the 65CE02 core.
- Consumes the core's look-ahead bus outputs (address_next, write_next, data_o_next) and returns data_i and ready.
- Splits each core cycle between two targets: on-chip fast memory with 1-cycle synchronous read, and a slow external region reached over a level req/ack handshake with programmable minimum wait states and a timeout.

Parameters:
- SLOW_BASE, 16'hD000: base of the slow region.
- SLOW_MASK, 16'hF000: slow hit when (addr & SLOW_MASK) == SLOW_BASE.
- WAIT_STATES, 2: minimum cycles req is held before ack may be accepted (0..15).
- TIMEOUT, 255: max cycles in S_WAIT before forced completion (1..255, must be > WAIT_STATES).

Ports:
- clk  in  1  core clock
- reset  in  1  active-low, asynchronous
- cpu_address_next  in  16  core next-cycle address
- cpu_write_next  in  1  core next-cycle write strobe
- cpu_data_o_next  in  8  core next-cycle write data
- cpu_ready  out  1  drives core ready
- cpu_data_i  out  8  drives core data_i
- fm_addr  out  16  fast memory address
- fm_we  out  1  fast memory write enable
- fm_wdata  out  8  fast memory write data
- fm_rdata  in  8  fast memory read data, valid 1 cycle after fm_addr
- sb_req  out  1  slow bus request (level)
- sb_we  out  1  slow bus write
- sb_addr  out  16  slow bus address, registered
- sb_wdata  out  8  slow bus write data, registered
- sb_rdata  in  8  slow bus read data, valid with sb_ack
- sb_ack  in  1  slow bus acknowledge (level)
- bus_timeout  out  1  1-cycle pulse on forced completion

Behaviour:
- Capture: at every posedge with cpu_ready=1, the cpu_*_next values become the current transaction. txn_slow <= slow_hit(cpu_address_next).
- Fast path (combinational):
  - fm_addr = cpu_address_next; fm_wdata = cpu_data_o_next.
  - fm_we = cpu_write_next & cpu_ready & ~slow_hit(cpu_address_next).
- States:
  - S_IDLE: serving fast txn or idle.
  - S_WAIT: slow txn outstanding.
  - S_DONE: slow txn complete.
- cpu_ready = 1 in S_IDLE and S_DONE; 0 in S_WAIT. It is registered-state-derived only, so there is no combinational path from cpu_* inputs.
- cpu_data_i = rd_latch in S_DONE, otherwise fm_rdata.
- Transitions:
  - S_IDLE/S_DONE --capture of slow hit--> S_WAIT. Same edge: sb_req<=1; sb_we/sb_addr/sb_wdata latch the next values; wcnt<=WAIT_STATES; tcnt<=0.
  - S_IDLE/S_DONE --capture of fast hit--> S_IDLE.
  - S_WAIT: wcnt decrements to 0 and saturates; tcnt increments every cycle.
  - Ack accepted when sb_ack=1 and wcnt==0. Then: rd_latch<=sb_rdata, sb_req<=0, go to S_DONE.
  - Ack while wcnt>0 is ignored; the slave must hold it.
  - Timeout: tcnt==TIMEOUT-1 without accepted ack. Then: rd_latch<=8'hFF, sb_req<=0, go to S_DONE, bus_timeout=1 for the S_DONE cycle only.
  - Ack and timeout in the same cycle: ack wins, no timeout pulse.
  - sb_ack in S_IDLE/S_DONE is ignored. A new req is not raised while sb_ack is still high from the previous txn: S_WAIT holds wcnt≥1 until sb_ack is seen low once, then resumes normal counting. This keeps the handshake 4-phase.
- Latency:
  - Fast txn: 1 cycle.
  - Slow txn: 2 + max(WAIT_STATES, ack delay) cycles. cpu_ready low for all but the last cycle.
  - Back-to-back slow txns: S_DONE goes directly to S_WAIT.
- Writes follow the same timing as reads. Slow writes complete only on ack or timeout; a timed-out write is dropped.
- Reset (async, any state):
  - State S_IDLE; sb_req=0, sb_we=0, sb_addr=0, sb_wdata=0.
  - rd_latch=0, wcnt=0, tcnt=0, txn_slow=0, bus_timeout=0.
  - cpu_ready=1 immediately; outstanding slow txn abandoned.
  - First posedge after release captures normally.

Test Plan:
- Fast read 0x0200, fm_rdata=8'h5A next cycle -> cpu_ready stays 1, cpu_data_i=8'h5A on the cycle after capture, sb_req never rises.
- Slow read 0xD012, WAIT_STATES=2, sb_ack held high from request, sb_rdata=8'hC3 -> sb_req high 3 cycles, cpu_ready low 3 cycles then 1, cpu_data_i=8'hC3 in S_DONE.
- Slow write 0xD7FF data 8'h99, ack at 5th req cycle -> sb_we=1, sb_addr=16'hD7FF, sb_wdata=8'h99 stable while sb_req=1; fm_we never asserted; txn takes 6 cycles.
- No ack, TIMEOUT=8 -> sb_req drops after 8 cycles, bus_timeout pulses 1 cycle, cpu_data_i=8'hFF, cpu_ready returns 1.
- Back-to-back slow txns with ack lingering 2 cycles after req drop -> second sb_req not accepted until sb_ack seen low; no double completion.
- Assert reset mid S_WAIT -> sb_req=0 and cpu_ready=1 asynchronously; after release a fast read completes in 1 cycle.
